bist_fail_capture: RTL and testbench
====================================

// Module: bist_fail_capture
// PURPOSE
//   Parametrised fail-capture unit for the SRAM BIST datapath. Compares expected vs
//   actual read data on each qualified read. Keeps a sticky go/no-go flag, a per-bit
//   fail map, a saturating fail counter and the address/syndrome of the first failure.
//   Sits between the BIST comparator stage and the BIST controller/status outputs.
// PARAMETERS
//   DATA_W  4  width of compared read data (one fail-map bit per data bit)
//   ADDR_W  8  width of captured address
//   CNT_W   8  width of the saturating fail counter
//   STICKY  1  1: go_nogo holds once set; 0: go_nogo shows only the previous cycle's compare
// PORTS
//   clk          in   1       clock, all state changes on posedge
//   rst          in   1       synchronous, active-high reset
//   clr          in   1       synchronous clear of all capture state (between test passes)
//   en           in   1       capture enable; when 0, cmp_valid is ignored
//   cmp_valid    in   1       exp_data/act_data/addr are valid this cycle
//   addr         in   ADDR_W  SRAM address of the compared read
//   exp_data     in   DATA_W  expected data
//   act_data     in   DATA_W  data read from SRAM
//   go_nogo      out  1       1 = NO-GO (failure seen), 0 = GO
//   fail_map     out  DATA_W  sticky OR of the per-bit mismatches
//   fail_cnt     out  CNT_W   number of failing compares, saturating
//   cnt_sat      out  1       fail_cnt has reached 2^CNT_W-1
//   first_valid  out  1       first-fail record is loaded
//   first_addr   out  ADDR_W  address of the first failing compare
//   first_syn    out  DATA_W  exp_data^act_data of the first failing compare
// BEHAVIOUR
//   - qual = en & cmp_valid; syn = exp_data ^ act_data; miss = qual & (|syn).
//   - Priority each edge: rst > clr > capture. rst and clr have the same effect.
//   - Reset/clear values: go_nogo=0, fail_map=0, fail_cnt=0, cnt_sat=0, first_valid=0,
//     first_addr=0, first_syn=0.
//   - Latency: every output reflects a compare one cycle after it is presented.
//     A compare on edge N is visible after edge N.
//   - fail_map <= fail_map | (qual ? syn : 0). A bit never clears except on rst/clr.
//   - STICKY=1: go_nogo <= go_nogo | miss.
//   - STICKY=0: go_nogo <= miss, so it returns to 0 on the cycle after a passing or
//     idle cycle.
//   - fail_cnt increments by 1 on each miss while below 2^CNT_W-1. At the max it holds
//     with no wrap. cnt_sat = (fail_cnt == 2^CNT_W-1), registered with fail_cnt.
//   - First-fail record: on a miss while first_valid=0, load first_addr=addr,
//     first_syn=syn and set first_valid=1. Later misses never overwrite the record.
//   - clr asserted in the same cycle as a miss: the clear wins and the miss is dropped.
//     The cycle after, all outputs are at their reset values.
//   - en=0 or cmp_valid=0: no state change except go_nogo in STICKY=0, which goes to 0.
//   - rst mid-test discards all captured state. Capture resumes on the first qualified
//     compare after rst deasserts.
//   - No combinational path from inputs to outputs. Outputs are registers only.
// TESTING
//   1 Reset, then 20 compares with exp==act at addr 0..19
//     -> go_nogo=0, fail_map=0, fail_cnt=0, first_valid=0.
//   2 Compare at addr 8'h3C with exp=4'hA, act=4'h8
//     -> next cycle go_nogo=1, fail_map=4'h2, fail_cnt=1, first_addr=8'h3C, first_syn=4'h2.
//   3 After (2), miss at addr 8'h50 with syn 4'h4
//     -> fail_map=4'h6, fail_cnt=2; first_addr stays 8'h3C, first_syn stays 4'h2.
//   4 CNT_W=2, drive 5 misses
//     -> fail_cnt sequence 1,2,3,3,3; cnt_sat=1 from the 3rd miss onward.
//   5 clr in the same cycle as a miss
//     -> all outputs 0 next cycle. Then a miss with en=0 -> still all 0.
//   6 STICKY=0: miss, pass, idle
//     -> go_nogo sequence 1,0,0 while fail_map holds the syndrome.
//     Assert rst mid-run -> all outputs 0.

Source files
------------

// File: rtl/bist_fail_capture.sv
// BIST fail-capture: sticky go/no-go, per-bit fail map,
// saturating fail counter and first-fail address/syndrome record.
module bist_fail_capture #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8,
  parameter int STICKY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] act_data,
  output logic              go_nogo,
  output logic [DATA_W-1:0] fail_map,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              cnt_sat,
  output logic              first_valid,
  output logic [ADDR_W-1:0] first_addr,
  output logic [DATA_W-1:0] first_syn
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              qual;
  logic              miss;
  logic [DATA_W-1:0] syn;
  logic              go_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign qual = en & cmp_valid;
  assign syn  = exp_data ^ act_data;
  assign miss = qual & (|syn);

  // Non-sticky mode shows only the most recent compare.
  assign go_nxt = (STICKY != 0) ? (go_nogo | miss) : miss;

  always_comb begin
    cnt_nxt = fail_cnt;
    if (miss && fail_cnt != CNT_MAX)
      cnt_nxt = fail_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      go_nogo     <= 1'b0;
      fail_map    <= '0;
      fail_cnt    <= '0;
      cnt_sat     <= 1'b0;
      first_valid <= 1'b0;
      first_addr  <= '0;
      first_syn   <= '0;
    end else begin
      go_nogo  <= go_nxt;
      fail_map <= fail_map | (qual ? syn : '0);
      fail_cnt <= cnt_nxt;
      cnt_sat  <= (cnt_nxt == CNT_MAX);
      if (miss && !first_valid) begin
        first_valid <= 1'b1;
        first_addr  <= addr;
        first_syn   <= syn;
      end
    end
  end

endmodule

// File: tb/tb_bist_fail_capture.sv
// Scoreboard bench for bist_fail_capture: three instances
// (default, CNT_W=2, STICKY=0) driven by shared directed vectors.
module tb_bist_fail_capture;

  logic       clk;
  logic       rst, clr, en, cmp_valid;
  logic [7:0] addr;
  logic [3:0] exp_data, act_data;

  logic [2:0] go;
  logic [3:0] map [3];
  logic [7:0] cnt [3];
  logic [1:0] cnt1;
  logic [2:0] sat, fv;
  logic [7:0] fa [3];
  logic [3:0] fs [3];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         sel;
    logic       go;
    logic [3:0] map;
    logic [7:0] cnt;
    logic       sat;
    logic       fv;
    logic [7:0] fa;
    logic [3:0] fs;
  } exp_t;

  exp_t sb [$];

  bist_fail_capture u0 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cmp_valid(cmp_valid),
    .addr(addr), .exp_data(exp_data), .act_data(act_data),
    .go_nogo(go[0]), .fail_map(map[0]), .fail_cnt(cnt[0]),
    .cnt_sat(sat[0]), .first_valid(fv[0]), .first_addr(fa[0]),
    .first_syn(fs[0])
  );

  bist_fail_capture #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cmp_valid(cmp_valid),
    .addr(addr), .exp_data(exp_data), .act_data(act_data),
    .go_nogo(go[1]), .fail_map(map[1]), .fail_cnt(cnt1),
    .cnt_sat(sat[1]), .first_valid(fv[1]), .first_addr(fa[1]),
    .first_syn(fs[1])
  );
  assign cnt[1] = {6'd0, cnt1};

  bist_fail_capture #(.STICKY(0)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cmp_valid(cmp_valid),
    .addr(addr), .exp_data(exp_data), .act_data(act_data),
    .go_nogo(go[2]), .fail_map(map[2]), .fail_cnt(cnt[2]),
    .cnt_sat(sat[2]), .first_valid(fv[2]), .first_addr(fa[2]),
    .first_syn(fs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int s,
                     input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, s, got, want, $time);
    end
  endtask

  // Monitor: one expectation per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("go_nogo", e.sel, {7'd0, go[e.sel]}, {7'd0, e.go});
        chk("fail_map", e.sel, {4'd0, map[e.sel]}, {4'd0, e.map});
        chk("fail_cnt", e.sel, cnt[e.sel], e.cnt);
        chk("cnt_sat", e.sel, {7'd0, sat[e.sel]}, {7'd0, e.sat});
        chk("first_valid", e.sel, {7'd0, fv[e.sel]}, {7'd0, e.fv});
        chk("first_addr", e.sel, fa[e.sel], e.fa);
        chk("first_syn", e.sel, {4'd0, fs[e.sel]}, {4'd0, e.fs});
      end
    end
  end

  task automatic step(
    input int s, input logic r, input logic c, input logic e_n,
    input logic v, input logic [7:0] a, input logic [3:0] ed,
    input logic [3:0] ad,
    input logic x_go, input logic [3:0] x_map, input logic [7:0] x_cnt,
    input logic x_sat, input logic x_fv, input logic [7:0] x_fa,
    input logic [3:0] x_fs
  );
    exp_t e;
    @(negedge clk);
    rst = r; clr = c; en = e_n; cmp_valid = v;
    addr = a; exp_data = ed; act_data = ad;
    e.sel = s; e.go = x_go; e.map = x_map; e.cnt = x_cnt;
    e.sat = x_sat; e.fv = x_fv; e.fa = x_fa; e.fs = x_fs;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b0; cmp_valid = 1'b0;
    addr = '0; exp_data = '0; act_data = '0;

    // Reset and 20 passing compares
    step(0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8'h00, 4'h0);
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 1, 1, 8'(i), 4'(i), 4'(i),
           0, 4'h0, 0, 0, 0, 8'h00, 4'h0);

    // First fail, then a second fail that must not overwrite the record
    step(0, 0, 0, 1, 1, 8'h3C, 4'hA, 4'h8, 1, 4'h2, 1, 0, 1, 8'h3C, 4'h2);
    step(0, 0, 0, 1, 1, 8'h50, 4'h5, 4'h1, 1, 4'h6, 2, 0, 1, 8'h3C, 4'h2);
    // Idle cycle keeps state in sticky mode
    step(0, 0, 0, 1, 0, 8'h60, 4'hF, 4'h0, 1, 4'h6, 2, 0, 1, 8'h3C, 4'h2);
    // Clear wins over a same-cycle miss, then a disabled miss is ignored
    step(0, 0, 1, 1, 1, 8'h70, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 8'h00, 4'h0);
    step(0, 0, 0, 0, 1, 8'h71, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 8'h00, 4'h0);

    // Saturating counter on the 2-bit instance
    step(1, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8'h00, 4'h0);
    step(1, 0, 0, 1, 1, 8'h01, 4'hF, 4'h0, 1, 4'hF, 1, 0, 1, 8'h01, 4'hF);
    step(1, 0, 0, 1, 1, 8'h02, 4'hF, 4'h0, 1, 4'hF, 2, 0, 1, 8'h01, 4'hF);
    step(1, 0, 0, 1, 1, 8'h03, 4'hF, 4'h0, 1, 4'hF, 3, 1, 1, 8'h01, 4'hF);
    step(1, 0, 0, 1, 1, 8'h04, 4'hF, 4'h0, 1, 4'hF, 3, 1, 1, 8'h01, 4'hF);
    step(1, 0, 0, 1, 1, 8'h05, 4'hF, 4'h0, 1, 4'hF, 3, 1, 1, 8'h01, 4'hF);

    // Non-sticky instance: miss, pass, idle, then reset mid-run
    step(2, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8'h00, 4'h0);
    step(2, 0, 0, 1, 1, 8'h07, 4'h3, 4'h1, 1, 4'h2, 1, 0, 1, 8'h07, 4'h2);
    step(2, 0, 0, 1, 1, 8'h08, 4'h9, 4'h9, 0, 4'h2, 1, 0, 1, 8'h07, 4'h2);
    step(2, 0, 0, 1, 0, 8'h09, 4'hF, 4'h0, 0, 4'h2, 1, 0, 1, 8'h07, 4'h2);
    step(2, 1, 0, 1, 1, 8'h0A, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 8'h00, 4'h0);
    // Capture resumes after reset
    step(2, 0, 0, 1, 1, 8'h0B, 4'h8, 4'h0, 1, 4'h8, 1, 0, 1, 8'h0B, 4'h8);

    @(negedge clk);
    en = 1'b0; cmp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 0, 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
